mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage with data-memory handshake FSM and MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned SW/SH instead of issuing them.
package rv32i_types;
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
    logic [3:0] regfilemux_sel;
  } rv32i_control_word;
endpackage

module mem_stage
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MEM_valid_i,
  input  rv32i_control_word MEM_ctrl_word_i,
  input  logic [4:0]        MEM_rd_i,
  input  logic [width-1:0]  MEM_alu_out_i,
  input  logic [width-1:0]  MEM_rs2_out_i,
  input  logic [width-1:0]  MEM_pc_out_i,
  input  logic [width-1:0]  MEM_u_imm_i,
  input  logic              MEM_br_en_i,
  output logic [width-1:0]  data_mem_address_o,
  output logic [width-1:0]  data_mem_wdata_o,
  output logic [3:0]        data_mem_mbe_o,
  output logic              data_mem_read_o,
  output logic              data_mem_write_o,
  input  logic [width-1:0]  data_mem_rdata_i,
  input  logic              data_mem_resp_i,
  output logic              MEM_stall_o,
  output logic              WB_valid_o,
  output rv32i_control_word WB_ctrl_word_o,
  output logic [4:0]        WB_rd_o,
  output logic              WB_br_en_o,
  output logic [width-1:0]  WB_alu_out_o,
  output logic [width-1:0]  WB_pc_out_o,
  output logic [width-1:0]  WB_u_imm_o,
  output logic [width-1:0]  WB_data_mem_address_o,
  output logic [width-1:0]  WB_data_mem_rdata_o,
  output logic              WB_misalign_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [1:0] off;
  logic [2:0] f3;
  logic is_ld, is_st, misalign, mem_op;
  always_comb begin
    off = MEM_alu_out_i[1:0];
    f3 = MEM_ctrl_word_i.funct3;
    is_ld = MEM_valid_i && MEM_ctrl_word_i.mem_read && !MEM_ctrl_word_i.mem_write;
    is_st = MEM_valid_i && MEM_ctrl_word_i.mem_write && !MEM_ctrl_word_i.mem_read;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = is_st && ((f3 == 3'b010 && off != 2'd0) || (f3 == 3'b001 && off == 2'd3));
`else
    misalign = 1'b0;
`endif
    mem_op = (is_ld || is_st) && !misalign;
    MEM_stall_o = mem_op && !data_mem_resp_i;
    data_mem_read_o = rst_n && mem_op && is_ld;
    data_mem_write_o = rst_n && mem_op && is_st;
    data_mem_address_o = {MEM_alu_out_i[width-1:2], 2'b00};
    data_mem_wdata_o = f3 == 3'b010 ? MEM_rs2_out_i : MEM_rs2_out_i << {off, 3'b000};
    data_mem_mbe_o = !data_mem_write_o ? 4'b0000 :
                     f3 == 3'b010 ? 4'b1111 :
                     f3 == 3'b001 ? 4'b0011 << off : 4'b0001 << off;
  end
  // The handshake itself is combinational; state tracks whether a request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (state == IDLE) state <= (mem_op && !data_mem_resp_i) ? BUSY : IDLE;
    else state <= (data_mem_resp_i || !mem_op) ? IDLE : BUSY;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_valid_o <= 1'b0;
      WB_ctrl_word_o <= '0;
      WB_rd_o <= '0;
      WB_br_en_o <= 1'b0;
      WB_alu_out_o <= '0;
      WB_pc_out_o <= '0;
      WB_u_imm_o <= '0;
      WB_data_mem_address_o <= '0;
      WB_data_mem_rdata_o <= '0;
      WB_misalign_o <= 1'b0;
    end else if (MEM_stall_o) begin
      WB_valid_o <= 1'b0;
      WB_ctrl_word_o.load_regfile <= 1'b0;
    end else begin
      WB_valid_o <= MEM_valid_i;
      WB_ctrl_word_o <= MEM_ctrl_word_i;
      WB_ctrl_word_o.load_regfile <= MEM_ctrl_word_i.load_regfile && MEM_valid_i && !misalign;
      WB_rd_o <= MEM_rd_i;
      WB_br_en_o <= MEM_br_en_i;
      WB_alu_out_o <= MEM_alu_out_i;
      WB_pc_out_o <= MEM_pc_out_i;
      WB_u_imm_o <= MEM_u_imm_i;
      WB_data_mem_address_o <= MEM_alu_out_i;
      WB_data_mem_rdata_o <= (mem_op && is_ld) ? data_mem_rdata_i : '0;
      WB_misalign_o <= misalign;
    end
  end
endmodule
